// File: rtl/sort_job_ctrl_if.sv
// Descriptor and completion handshake between the host side (master) and sort_job_ctrl (slave).
interface sort_job_ctrl_if #(
  parameter int unsigned DATA_WIDTH   = 1024,
  parameter int unsigned RETURN_WIDTH = 64
);
  logic                    engine_start;
  logic                    engine_ready;
  logic [DATA_WIDTH-1:0]   engine_data;
  logic                    complete_ready;
  logic                    complete_accept;
  logic [RETURN_WIDTH-1:0] complete_data;

  modport master (
    output engine_start, engine_data, complete_accept,
    input  engine_ready, complete_ready, complete_data
  );

  modport slave (
    input  engine_start, engine_data, complete_accept,
    output engine_ready, complete_ready, complete_data
  );
endinterface

// File: rtl/sort_job_ctrl.sv
// Sort engine job sequencer: takes one descriptor, steps fetch -> sort -> return and posts
// a completion record {cycle count, status, job id}.
//
// state  | meaning
// IDLE   | ready for a descriptor
// FETCH  | fetch stage running, waiting for fetch_done
// SORT   | sort stage running, waiting for sort_done
// RETURN | return stage running, waiting for return_done
// CMPL   | completion posted, waiting for complete_accept
// FAULT  | a phase timed out; parked until rst
module sort_job_ctrl #(
  parameter int unsigned DATA_WIDTH     = 1024,
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned PASID_WIDTH    = 20,
  parameter int unsigned RETURN_WIDTH   = 64,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   rst,
  sort_job_ctrl_if.slave         eng,
  output logic                   engine_fault,
  output logic                   fetch_start,
  input  logic                   fetch_done,
  output logic [PASID_WIDTH-1:0] fetch_pasid,
  output logic [ADDR_WIDTH-1:0]  fetch_start_addr,
  output logic [5:0]             fetch_beat_num,
  output logic                   sort_start,
  input  logic                   sort_done,
  output logic                   return_start,
  input  logic                   return_done,
  output logic [PASID_WIDTH-1:0] return_pasid,
  output logic [ADDR_WIDTH-1:0]  return_start_addr,
  output logic [5:0]             return_beat_num
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SORT, S_RETURN, S_CMPL, S_FAULT
  } state_e;

  localparam logic [7:0] ST_OK         = 8'd0;
  localparam logic [7:0] ST_BAD_LEN    = 8'd1;
  localparam logic [7:0] ST_TMO_FETCH  = 8'd2;
  localparam logic [7:0] ST_TMO_SORT   = 8'd3;
  localparam logic [7:0] ST_TMO_RETURN = 8'd4;

  localparam int unsigned PH_W       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMO_LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(TMO_LAST_I);

  state_e                  state_q, state_d;
  logic                    engine_ready_q, engine_ready_d;
  logic                    complete_ready_q, complete_ready_d;
  logic [RETURN_WIDTH-1:0] complete_data_q, complete_data_d;
  logic                    engine_fault_q, engine_fault_d;
  logic                    fetch_start_q, fetch_start_d;
  logic                    sort_start_q, sort_start_d;
  logic                    return_start_q, return_start_d;
  logic [ADDR_WIDTH-1:0]   src_addr_q, src_addr_d;
  logic [ADDR_WIDTH-1:0]   dst_addr_q, dst_addr_d;
  logic [PASID_WIDTH-1:0]  pasid_q, pasid_d;
  logic [5:0]              fetch_beats_q, fetch_beats_d;
  logic [5:0]              return_beats_q, return_beats_d;
  logic [31:0]             job_id_q, job_id_d;
  logic [PH_W-1:0]         ph_q, ph_d;
  logic [23:0]             cyc_q, cyc_d;

  logic [ADDR_WIDTH-1:0]   desc_src;
  logic [ADDR_WIDTH-1:0]   desc_dst;
  logic [5:0]              desc_fbeats;
  logic [5:0]              desc_rbeats;
  logic [PASID_WIDTH-1:0]  desc_pasid;
  logic [31:0]             desc_id;
  logic                    unused_desc;

  logic                    tmo_hit;
  logic [23:0]             cyc_inc;
  logic                    fin;
  logic [7:0]              fin_status;
  logic [23:0]             fin_cnt;
  logic [31:0]             fin_id;

  assign desc_src    = eng.engine_data[ADDR_WIDTH-1:0];
  assign desc_dst    = eng.engine_data[64 +: ADDR_WIDTH];
  assign desc_fbeats = eng.engine_data[133:128];
  assign desc_rbeats = eng.engine_data[139:134];
  assign desc_pasid  = eng.engine_data[140 +: PASID_WIDTH];
  assign desc_id     = eng.engine_data[191:160];
  assign unused_desc = ^eng.engine_data[DATA_WIDTH-1:192];

  assign tmo_hit = (TIMEOUT_CYCLES != 0) && (ph_q == PH_LAST);
  assign cyc_inc = (cyc_q == 24'hFF_FFFF) ? cyc_q : cyc_q + 24'd1;

  always_comb begin
    state_d          = state_q;
    engine_ready_d   = 1'b0;
    complete_ready_d = complete_ready_q;
    complete_data_d  = complete_data_q;
    engine_fault_d   = engine_fault_q;
    fetch_start_d    = 1'b0;
    sort_start_d     = 1'b0;
    return_start_d   = 1'b0;
    src_addr_d       = src_addr_q;
    dst_addr_d       = dst_addr_q;
    pasid_d          = pasid_q;
    fetch_beats_d    = fetch_beats_q;
    return_beats_d   = return_beats_q;
    job_id_d         = job_id_q;
    ph_d             = ph_q + PH_W'(1);
    cyc_d            = cyc_q;
    fin              = 1'b0;
    fin_status       = ST_OK;
    fin_cnt          = cyc_q;
    fin_id           = job_id_q;

    case (state_q)
      S_IDLE: begin
        engine_ready_d = 1'b1;
        if (engine_ready_q && eng.engine_start) begin
          engine_ready_d = 1'b0;
          src_addr_d     = desc_src;
          dst_addr_d     = desc_dst;
          pasid_d        = desc_pasid;
          fetch_beats_d  = desc_fbeats;
          return_beats_d = desc_rbeats;
          job_id_d       = desc_id;
          if (desc_fbeats == 6'd0 || desc_rbeats == 6'd0) begin
            fin        = 1'b1;
            fin_status = ST_BAD_LEN;
            fin_cnt    = 24'd0;
            fin_id     = desc_id;
          end else begin
            state_d       = S_FETCH;
            fetch_start_d = 1'b1;
            ph_d          = '0;
            cyc_d         = 24'd1;
          end
        end
      end
      // A done coinciding with the phase's own start pulse is treated as stale.
      S_FETCH: begin
        cyc_d = cyc_inc;
        if (!fetch_start_q && fetch_done) begin
          state_d      = S_SORT;
          sort_start_d = 1'b1;
          ph_d         = '0;
        end else if (tmo_hit) begin
          fin            = 1'b1;
          fin_status     = ST_TMO_FETCH;
          engine_fault_d = 1'b1;
        end
      end
      S_SORT: begin
        cyc_d = cyc_inc;
        if (!sort_start_q && sort_done) begin
          state_d        = S_RETURN;
          return_start_d = 1'b1;
          ph_d           = '0;
        end else if (tmo_hit) begin
          fin            = 1'b1;
          fin_status     = ST_TMO_SORT;
          engine_fault_d = 1'b1;
        end
      end
      S_RETURN: begin
        cyc_d = cyc_inc;
        if (!return_start_q && return_done) begin
          fin = 1'b1;
        end else if (tmo_hit) begin
          fin            = 1'b1;
          fin_status     = ST_TMO_RETURN;
          engine_fault_d = 1'b1;
        end
      end
      S_CMPL: begin
        if (eng.complete_accept) begin
          complete_ready_d = 1'b0;
          if (complete_data_q[39:32] == ST_OK || complete_data_q[39:32] == ST_BAD_LEN) begin
            state_d        = S_IDLE;
            engine_ready_d = 1'b1;
          end else begin
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    if (fin) begin
      state_d                = S_CMPL;
      complete_ready_d       = 1'b1;
      complete_data_d        = '0;
      complete_data_d[63:0]  = {fin_cnt, fin_status, fin_id};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= S_IDLE;
      engine_ready_q   <= 1'b0;
      complete_ready_q <= 1'b0;
      complete_data_q  <= '0;
      engine_fault_q   <= 1'b0;
      fetch_start_q    <= 1'b0;
      sort_start_q     <= 1'b0;
      return_start_q   <= 1'b0;
      src_addr_q       <= '0;
      dst_addr_q       <= '0;
      pasid_q          <= '0;
      fetch_beats_q    <= '0;
      return_beats_q   <= '0;
      job_id_q         <= '0;
      ph_q             <= '0;
      cyc_q            <= '0;
    end else begin
      state_q          <= state_d;
      engine_ready_q   <= engine_ready_d;
      complete_ready_q <= complete_ready_d;
      complete_data_q  <= complete_data_d;
      engine_fault_q   <= engine_fault_d;
      fetch_start_q    <= fetch_start_d;
      sort_start_q     <= sort_start_d;
      return_start_q   <= return_start_d;
      src_addr_q       <= src_addr_d;
      dst_addr_q       <= dst_addr_d;
      pasid_q          <= pasid_d;
      fetch_beats_q    <= fetch_beats_d;
      return_beats_q   <= return_beats_d;
      job_id_q         <= job_id_d;
      ph_q             <= ph_d;
      cyc_q            <= cyc_d;
    end
  end

  assign eng.engine_ready   = engine_ready_q;
  assign eng.complete_ready = complete_ready_q;
  assign eng.complete_data  = complete_data_q;
  assign engine_fault       = engine_fault_q;
  assign fetch_start        = fetch_start_q;
  assign sort_start         = sort_start_q;
  assign return_start       = return_start_q;
  assign fetch_pasid        = pasid_q;
  assign return_pasid       = pasid_q;
  assign fetch_start_addr   = src_addr_q;
  assign return_start_addr  = dst_addr_q;
  assign fetch_beat_num     = fetch_beats_q;
  assign return_beat_num    = return_beats_q;

endmodule

// File: tb/tb_sort_job_ctrl.sv
// Directed bench for sort_job_ctrl: normal job, bad length, held completion, spurious dones,
// mid-job reset and sort-phase timeout (TIMEOUT_CYCLES=16).
module tb_sort_job_ctrl;
  localparam int DW  = 1024;
  localparam int AW  = 64;
  localparam int PW  = 20;
  localparam int RW  = 64;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          engine_fault;
  logic          fetch_start, fetch_done;
  logic          sort_start, sort_done;
  logic          return_start, return_done;
  logic [PW-1:0] fetch_pasid, return_pasid;
  logic [AW-1:0] fetch_start_addr, return_start_addr;
  logic [5:0]    fetch_beat_num, return_beat_num;

  int checks   = 0;
  int failures = 0;

  sort_job_ctrl_if #(.DATA_WIDTH(DW), .RETURN_WIDTH(RW)) eng ();

  sort_job_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PASID_WIDTH(PW),
    .RETURN_WIDTH(RW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .eng(eng),
    .engine_fault(engine_fault),
    .fetch_start(fetch_start), .fetch_done(fetch_done),
    .fetch_pasid(fetch_pasid), .fetch_start_addr(fetch_start_addr),
    .fetch_beat_num(fetch_beat_num),
    .sort_start(sort_start), .sort_done(sort_done),
    .return_start(return_start), .return_done(return_done),
    .return_pasid(return_pasid), .return_start_addr(return_start_addr),
    .return_beat_num(return_beat_num)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [DW-1:0] mk_desc(input logic [63:0] src, input logic [63:0] dst,
                                            input logic [5:0] fb, input logic [5:0] rb,
                                            input logic [19:0] pasid, input logic [31:0] id);
    logic [DW-1:0] d;
    d = {((DW - 192) / 32 + 6){32'hDEAD_BEEF}};
    d[63:0]    = src;
    d[127:64]  = dst;
    d[133:128] = fb;
    d[139:134] = rb;
    d[159:140] = pasid;
    d[191:160] = id;
    return d;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    eng.engine_start = 1'b0; eng.complete_accept = 1'b0; eng.engine_data = '0;
    fetch_done = 1'b0; sort_done = 1'b0; return_done = 1'b0;
    tick(2);
    checks++;
    if ({eng.engine_ready, eng.complete_ready, engine_fault, fetch_start, sort_start, return_start} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000000",
               {eng.engine_ready, eng.complete_ready, engine_fault, fetch_start, sort_start, return_start});
    end
    checks++;
    if (eng.complete_data !== 64'h0 || fetch_start_addr !== 64'h0 || fetch_pasid !== 20'h0) begin
      failures++;
      $display("FAIL reset_data cdata=%h faddr=%h pasid=%h exp=0", eng.complete_data, fetch_start_addr, fetch_pasid);
    end
    rst = 1'b0;
    tick(1);
    checks++;
    if (eng.engine_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%b exp=1", eng.engine_ready);
    end
  endtask

  task automatic test_basic_job();
    eng.engine_data  = mk_desc(64'h1000, 64'h2000, 6'd4, 6'd4, 20'h12345, 32'd7);
    eng.engine_start = 1'b1;
    tick(1);
    eng.engine_start = 1'b0;
    checks++;
    if (fetch_start !== 1'b1 || eng.engine_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_accept fetch_start=%b ready=%b exp fetch_start=1 ready=0", fetch_start, eng.engine_ready);
    end
    checks++;
    if (fetch_start_addr !== 64'h1000 || return_start_addr !== 64'h2000 || fetch_beat_num !== 6'd4 ||
        return_beat_num !== 6'd4 || fetch_pasid !== 20'h12345 || return_pasid !== 20'h12345) begin
      failures++;
      $display("FAIL basic_desc src=%h dst=%h fb=%0d rb=%0d fp=%h rp=%h exp 1000/2000/4/4/12345/12345",
               fetch_start_addr, return_start_addr, fetch_beat_num, return_beat_num, fetch_pasid, return_pasid);
    end
    tick(1);
    checks++;
    if (fetch_start !== 1'b0) begin
      failures++;
      $display("FAIL basic_fetch_pulse_width got=%b exp=0", fetch_start);
    end
    tick(4);
    fetch_done = 1'b1;
    tick(1);
    fetch_done = 1'b0;
    checks++;
    if (sort_start !== 1'b1 || fetch_start !== 1'b0 || return_start !== 1'b0) begin
      failures++;
      $display("FAIL basic_sort_start f/s/r=%b%b%b exp=010", fetch_start, sort_start, return_start);
    end
    tick(5);
    sort_done = 1'b1;
    tick(1);
    sort_done = 1'b0;
    checks++;
    if (return_start !== 1'b1 || sort_start !== 1'b0) begin
      failures++;
      $display("FAIL basic_return_start s/r=%b%b exp=01", sort_start, return_start);
    end
    tick(5);
    checks++;
    if (eng.complete_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_complete got=%b exp=0", eng.complete_ready);
    end
    return_done = 1'b1;
    tick(1);
    return_done = 1'b0;
    checks++;
    if (eng.complete_ready !== 1'b1 || eng.complete_data !== 64'h0000_1200_0000_0007) begin
      failures++;
      $display("FAIL basic_completion ready=%b data=%h exp ready=1 data=0000120000000007",
               eng.complete_ready, eng.complete_data);
    end
    eng.complete_accept = 1'b1;
    tick(1);
    eng.complete_accept = 1'b0;
    checks++;
    if (eng.complete_ready !== 1'b0 || eng.engine_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_after_accept complete_ready=%b ready=%b exp 0/1", eng.complete_ready, eng.engine_ready);
    end
  endtask

  task automatic test_bad_len();
    eng.engine_data  = mk_desc(64'h5000, 64'h6000, 6'd0, 6'd4, 20'h00111, 32'h55);
    eng.engine_start = 1'b1;
    tick(1);
    eng.engine_start = 1'b0;
    checks++;
    if (eng.complete_ready !== 1'b1 || eng.complete_data !== 64'h0000_0001_0000_0055) begin
      failures++;
      $display("FAIL badlen_completion ready=%b data=%h exp ready=1 data=0000000100000055",
               eng.complete_ready, eng.complete_data);
    end
    checks++;
    if (fetch_start !== 1'b0 || eng.engine_ready !== 1'b0) begin
      failures++;
      $display("FAIL badlen_no_start fetch_start=%b ready=%b exp 0/0", fetch_start, eng.engine_ready);
    end
    tick(2);
    checks++;
    if ({fetch_start, sort_start, return_start} !== 3'b000) begin
      failures++;
      $display("FAIL badlen_pulses got=%b exp=000", {fetch_start, sort_start, return_start});
    end
    eng.complete_accept = 1'b1;
    tick(1);
    eng.complete_accept = 1'b0;
    checks++;
    if (eng.engine_ready !== 1'b1 || engine_fault !== 1'b0) begin
      failures++;
      $display("FAIL badlen_back_to_idle ready=%b fault=%b exp 1/0", eng.engine_ready, engine_fault);
    end
  endtask

  task automatic test_hold_accept();
    int bad;
    bad = 0;
    eng.engine_data  = mk_desc(64'hAAAA0, 64'hBBBB0, 6'd3, 6'd0, 20'h00222, 32'h99);
    eng.engine_start = 1'b1;
    tick(1);
    eng.engine_data  = mk_desc(64'hCCCC0, 64'hDDDD0, 6'd5, 6'd5, 20'h00333, 32'h77);
    for (int i = 0; i < 20; i++) begin
      if (eng.complete_ready !== 1'b1 || eng.complete_data !== 64'h0000_0001_0000_0099 ||
          eng.engine_ready !== 1'b0 || fetch_start !== 1'b0)
        bad++;
      tick(1);
    end
    eng.engine_start = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL hold_stable unstable_cycles=%0d exp=0", bad);
    end
    checks++;
    if (fetch_start_addr !== 64'hAAAA0 || eng.complete_data !== 64'h0000_0001_0000_0099) begin
      failures++;
      $display("FAIL hold_start_ignored faddr=%h data=%h exp faddr=aaaa0 data=0000000100000099",
               fetch_start_addr, eng.complete_data);
    end
    eng.complete_accept = 1'b1;
    tick(1);
    eng.complete_accept = 1'b0;
    checks++;
    if (eng.complete_ready !== 1'b0 || eng.engine_ready !== 1'b1) begin
      failures++;
      $display("FAIL hold_after_accept complete_ready=%b ready=%b exp 0/1", eng.complete_ready, eng.engine_ready);
    end
  endtask

  task automatic test_spurious_and_rst();
    eng.engine_data  = mk_desc(64'h3000, 64'h4000, 6'd2, 6'd3, 20'hABCDE, 32'h21);
    eng.engine_start = 1'b1;
    fetch_done       = 1'b1;
    tick(1);
    eng.engine_start = 1'b0;
    tick(1);
    fetch_done = 1'b0;
    checks++;
    if (sort_start !== 1'b0) begin
      failures++;
      $display("FAIL spurious_fetch_done_on_start sort_start=%b exp=0", sort_start);
    end
    sort_done = 1'b1;
    tick(1);
    sort_done = 1'b0;
    checks++;
    if (sort_start !== 1'b0 || return_start !== 1'b0) begin
      failures++;
      $display("FAIL spurious_sort_done_in_fetch s/r=%b%b exp=00", sort_start, return_start);
    end
    tick(1);
    fetch_done = 1'b1;
    tick(1);
    fetch_done = 1'b0;
    checks++;
    if (sort_start !== 1'b1) begin
      failures++;
      $display("FAIL spurious_still_fetch sort_start=%b exp=1", sort_start);
    end
    tick(1);
    sort_done = 1'b1;
    tick(1);
    sort_done = 1'b0;
    checks++;
    if (return_start !== 1'b1) begin
      failures++;
      $display("FAIL rstjob_return_start got=%b exp=1", return_start);
    end
    tick(1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    return_done = 1'b1;
    checks++;
    if (eng.engine_ready !== 1'b0 || eng.complete_ready !== 1'b0 || return_start_addr !== 64'h0 ||
        return_pasid !== 20'h0 || return_beat_num !== 6'd0) begin
      failures++;
      $display("FAIL rst_midjob_outputs ready=%b cr=%b raddr=%h rp=%h rb=%0d exp all 0",
               eng.engine_ready, eng.complete_ready, return_start_addr, return_pasid, return_beat_num);
    end
    tick(1);
    checks++;
    if (eng.engine_ready !== 1'b1 || eng.complete_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_midjob_idle ready=%b cr=%b exp 1/0", eng.engine_ready, eng.complete_ready);
    end
    tick(1);
    return_done = 1'b0;
    checks++;
    if (eng.complete_ready !== 1'b0 || eng.complete_data !== 64'h0) begin
      failures++;
      $display("FAIL rst_midjob_no_completion cr=%b data=%h exp 0/0", eng.complete_ready, eng.complete_data);
    end
  endtask

  task automatic test_timeout();
    int bad;
    bad = 0;
    eng.engine_data  = mk_desc(64'h7000, 64'h8000, 6'd1, 6'd1, 20'h00444, 32'h33);
    eng.engine_start = 1'b1;
    tick(1);
    eng.engine_start = 1'b0;
    tick(1);
    fetch_done = 1'b1;
    tick(1);
    fetch_done = 1'b0;
    checks++;
    if (sort_start !== 1'b1) begin
      failures++;
      $display("FAIL tmo_sort_start got=%b exp=1", sort_start);
    end
    tick(15);
    checks++;
    if (eng.complete_ready !== 1'b0 || engine_fault !== 1'b0) begin
      failures++;
      $display("FAIL tmo_early cr=%b fault=%b exp 0/0", eng.complete_ready, engine_fault);
    end
    tick(1);
    checks++;
    if (eng.complete_ready !== 1'b1 || engine_fault !== 1'b1 || eng.complete_data !== 64'h0000_1203_0000_0033) begin
      failures++;
      $display("FAIL tmo_completion cr=%b fault=%b data=%h exp 1/1/0000120300000033",
               eng.complete_ready, engine_fault, eng.complete_data);
    end
    checks++;
    if (return_start !== 1'b0) begin
      failures++;
      $display("FAIL tmo_no_return got=%b exp=0", return_start);
    end
    eng.complete_accept = 1'b1;
    tick(1);
    eng.complete_accept = 1'b0;
    eng.engine_data  = mk_desc(64'h9000, 64'hA000, 6'd2, 6'd2, 20'h00555, 32'h44);
    eng.engine_start = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (eng.engine_ready !== 1'b0 || fetch_start !== 1'b0 || eng.complete_ready !== 1'b0 ||
          engine_fault !== 1'b1)
        bad++;
      tick(1);
    end
    eng.engine_start = 1'b0;
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL tmo_fault_parked bad_cycles=%0d exp=0", bad);
    end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++;
    if (engine_fault !== 1'b0) begin
      failures++;
      $display("FAIL tmo_fault_cleared got=%b exp=0", engine_fault);
    end
    tick(1);
    checks++;
    if (eng.engine_ready !== 1'b1) begin
      failures++;
      $display("FAIL tmo_ready_after_rst got=%b exp=1", eng.engine_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_bad_len();
    test_hold_accept();
    test_spurious_and_rst();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
